// File: rtl/jbi_pktin_ctlr.sv
// JBus inbound packet controller: checks and frames J_AD cycles into sop/eop beat writes.
// Optional parity checking is enabled by defining JBI_PKTIN_PARITY_CHK_EN.
module jbi_pktin_ctlr (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [7:0]   in_adtype,
  input  logic [127:0] in_ad,
  input  logic [3:0]   in_adp,
  input  logic         inq_full,
  output logic         wr_en,
  output logic         wr_sop,
  output logic         wr_eop,
  output logic [3:0]   wr_type,
  output logic [127:0] wr_data,
  output logic         wr_perr,
  output logic         wr_abort,
  output logic         err_proto,
  output logic         err_parity,
  output logic         err_ovf
);

  // SKIP swallows the data cycles that follow an unknown-type header.
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, SKIP = 2'd2} state_t;

  state_t     state;
  logic [1:0] beats_left;
  logic       drop;

  logic       is_hdr;
  logic       is_dat;
  logic       type_ok;
  logic [2:0] nb;
  logic       nb_zero;
  logic       perr;

  // {legal, data beat count} for each transaction type
  function automatic logic [3:0] type_info(input logic [3:0] t);
    case (t)
      4'h1, 4'h4, 4'h5: return {1'b1, 3'd0};
      4'h2, 4'h6:       return {1'b1, 3'd1};
      4'h3, 4'h7:       return {1'b1, 3'd4};
      default:          return 4'b0000;
    endcase
  endfunction

  assign is_hdr          = (in_adtype[7:6] == 2'b10);
  assign is_dat          = (in_adtype[7:6] == 2'b01);
  assign {type_ok, nb}   = type_info(in_adtype[3:0]);
  assign nb_zero         = (nb == 3'd0);

`ifdef JBI_PKTIN_PARITY_CHK_EN
  // Each lane carries odd parity; an even total over lane plus parity bit is an error.
  function automatic logic lane_err(input logic [127:0] d, input logic [3:0] p);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++) e = e | ~(^{d[32*i +: 32], p[i]});
    return e;
  endfunction

  assign perr = lane_err(in_ad, in_adp);

  logic unused_bits;
  assign unused_bits = ^in_adtype[5:4];
`else
  assign perr = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{in_adp, in_adtype[5:4]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beats_left <= 2'd0;
      drop       <= 1'b0;
      wr_en      <= 1'b0;
      wr_sop     <= 1'b0;
      wr_eop     <= 1'b0;
      wr_type    <= 4'd0;
      wr_data    <= '0;
      wr_perr    <= 1'b0;
      wr_abort   <= 1'b0;
      err_proto  <= 1'b0;
      err_parity <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      wr_sop     <= 1'b0;
      wr_eop     <= 1'b0;
      wr_perr    <= 1'b0;
      wr_abort   <= 1'b0;
      err_proto  <= 1'b0;
      err_parity <= 1'b0;
      err_ovf    <= 1'b0;
      if (in_vld && is_hdr) begin
        // A header inside an open packet voids it; the new header is still taken this cycle.
        if (state == DATA) begin
          err_proto <= 1'b1;
          wr_abort  <= ~drop;
        end
        if (!type_ok) begin
          err_proto  <= 1'b1;
          state      <= SKIP;
          drop       <= 1'b0;
          beats_left <= 2'd0;
        end else begin
          err_parity <= perr;
          beats_left <= nb_zero ? 2'd0 : 2'(nb - 3'd1);
          state      <= nb_zero ? IDLE : DATA;
          drop       <= inq_full & ~nb_zero;
          if (inq_full) begin
            err_ovf <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_sop  <= 1'b1;
            wr_eop  <= nb_zero;
            wr_type <= in_adtype[3:0];
            wr_data <= in_ad;
            wr_perr <= perr;
          end
        end
      end else if (in_vld && is_dat) begin
        if (state == DATA) begin
          err_parity <= perr;
          if (!drop) begin
            wr_en   <= 1'b1;
            wr_eop  <= (beats_left == 2'd0);
            wr_data <= in_ad;
            wr_perr <= perr;
          end
          if (beats_left == 2'd0) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else begin
            beats_left <= beats_left - 2'd1;
          end
        end else if (state == IDLE) begin
          err_proto <= 1'b1;
        end
      end else if (in_vld || state == DATA) begin
        // Illegal cycle type, or a gap between data beats.
        err_proto <= 1'b1;
        if (state == DATA) begin
          wr_abort   <= ~drop;
          state      <= IDLE;
          drop       <= 1'b0;
          beats_left <= 2'd0;
        end
      end
    end
  end

endmodule
